// File: rtl/top_pkg.sv
// Shared types and constants for the counting stream source.
package top_pkg;

    localparam int unsigned DATA_W = 64;

    typedef logic [DATA_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        EOS,
        DONE
    } state_t;

    // Width needed to hold 0..count, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned count);
        int unsigned w;
        w = $clog2(count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/top_elem_gen.sv
// Element generator: value register and element counter for the stream source.
// Load restarts the sequence at START; each advance steps the value by STEP
// (wrapping modulo 2^64) and bumps the counter. last flags the final element.
module top_elem_gen
    import top_pkg::*;
#(
    parameter int unsigned COUNT = 10,
    parameter elem_t       START = '0,
    parameter elem_t       STEP  = 64'd1
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  logic  advance,
    output elem_t value,
    output logic  last
);

    localparam int unsigned CNT_W = cnt_width(COUNT);
    // Index of the final element; irrelevant when COUNT is zero because no
    // element is ever emitted in that configuration.
    localparam logic [CNT_W-1:0] LAST_IDX = (COUNT != 0) ? CNT_W'(COUNT - 1) : '0;

    logic [CNT_W-1:0] count;

    // Value register and element counter, restarted on load, stepped on advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= START;
            count <= '0;
        end else if (advance) begin
            value <= value + STEP;
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == LAST_IDX);

endmodule

// File: rtl/top.sv
// Counting stream source. A token on inCtrl starts a stream of COUNT elements
// START, START+STEP, ... on out0, paired with an EOS flag of 0 on out1; then a
// lone EOS flag of 1 on out1, then a completion token on outCtrl.
// Optional macro TOP_ASSERT_EN compiles in simulation-only handshake assertions.
module top
    import top_pkg::*;
#(
    parameter int unsigned COUNT = 10,
    parameter elem_t       START = '0,
    parameter elem_t       STEP  = 64'd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inCtrl_valid,
    output logic              inCtrl_ready,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic              out1_data,
    output logic              outCtrl_valid,
    input  logic              outCtrl_ready
);

    state_t state;
    elem_t  value;
    logic   last;
    logic   load;
    logic   advance;

    // inCtrl_ready is only high in IDLE, so this is the start-token transfer.
    assign load    = inCtrl_valid && inCtrl_ready;
    // An element leaves only when both element and flag consumers take it together.
    assign advance = (state == EMIT) && out0_ready && out1_ready;

    top_elem_gen #(
        .COUNT (COUNT),
        .START (START),
        .STEP  (STEP)
    ) u_elem_gen (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .advance (advance),
        .value   (value),
        .last    (last)
    );

    assign out0_data = value;

    // Stream FSM with registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            inCtrl_ready  <= 1'b1;
            out0_valid    <= 1'b0;
            out1_valid    <= 1'b0;
            out1_data     <= 1'b0;
            outCtrl_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        inCtrl_ready <= 1'b0;
                        out1_valid   <= 1'b1;
                        if (COUNT != 0) begin
                            state      <= EMIT;
                            out0_valid <= 1'b1;
                            out1_data  <= 1'b0;
                        end else begin
                            state      <= EOS;
                            out0_valid <= 1'b0;
                            out1_data  <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (advance && last) begin
                        state      <= EOS;
                        out0_valid <= 1'b0;
                        out1_data  <= 1'b1;
                    end
                end
                EOS: begin
                    if (out1_ready) begin
                        state         <= DONE;
                        out1_valid    <= 1'b0;
                        out1_data     <= 1'b0;
                        outCtrl_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (outCtrl_ready) begin
                        state         <= IDLE;
                        outCtrl_valid <= 1'b0;
                        inCtrl_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    inCtrl_ready  <= 1'b1;
                    out0_valid    <= 1'b0;
                    out1_valid    <= 1'b0;
                    out1_data     <= 1'b0;
                    outCtrl_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TOP_ASSERT_EN
    a_out0_hold: assert property (@(posedge clock) disable iff (!reset)
        out0_valid && !(out0_ready && out1_ready) |=> out0_valid && $stable(out0_data));
    a_out1_hold: assert property (@(posedge clock) disable iff (!reset)
        out1_valid && !out1_ready |=> out1_valid && $stable(out1_data));
    a_ctrl_hold: assert property (@(posedge clock) disable iff (!reset)
        outCtrl_valid && !outCtrl_ready |=> outCtrl_valid);
    a_elem_not_eos: assert property (@(posedge clock) disable iff (!reset)
        !(out0_valid && out1_data));
    a_emit_paired: assert property (@(posedge clock) disable iff (!reset)
        (state == EMIT) |-> (out0_valid == out1_valid));
    a_state_excl: assert property (@(posedge clock) disable iff (!reset)
        $onehot0({state == EMIT, state == EOS, state == DONE}));
`endif

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the counting stream source: three instances cover the
// default stream, an empty stream and a wrapping 64-bit sequence.
module tb_top;
    import top_pkg::*;

    typedef struct packed {
        logic [1:0] inst;
        logic [1:0] kind;   // 0 element, 1 EOS, 2 completion
        elem_t      data;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  in_v[3];
    logic  in_r[3];
    logic  o0v[3];
    logic  o0r[3];
    elem_t o0d[3];
    logic  o1v[3];
    logic  o1r[3];
    logic  o1d[3];
    logic  cv[3];
    logic  cr[3];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    n_elem = 0;
    int    ctrl_cyc = 0;
    int    accept_cyc = 0;
    int    rdy_mode = 0;
    bit    seen_o0v1 = 1'b0;
    logic  stall0[3];
    elem_t prev_d[3];
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    top dut0 (
        .clock(clk), .reset(rst_n),
        .inCtrl_valid(in_v[0]), .inCtrl_ready(in_r[0]),
        .out0_valid(o0v[0]), .out0_ready(o0r[0]), .out0_data(o0d[0]),
        .out1_valid(o1v[0]), .out1_ready(o1r[0]), .out1_data(o1d[0]),
        .outCtrl_valid(cv[0]), .outCtrl_ready(cr[0])
    );

    top #(.COUNT(0)) dut1 (
        .clock(clk), .reset(rst_n),
        .inCtrl_valid(in_v[1]), .inCtrl_ready(in_r[1]),
        .out0_valid(o0v[1]), .out0_ready(o0r[1]), .out0_data(o0d[1]),
        .out1_valid(o1v[1]), .out1_ready(o1r[1]), .out1_data(o1d[1]),
        .outCtrl_valid(cv[1]), .outCtrl_ready(cr[1])
    );

    top #(.COUNT(4), .START(64'hFFFF_FFFF_FFFF_FFFE), .STEP(64'd1)) dut2 (
        .clock(clk), .reset(rst_n),
        .inCtrl_valid(in_v[2]), .inCtrl_ready(in_r[2]),
        .out0_valid(o0v[2]), .out0_ready(o0r[2]), .out0_data(o0d[2]),
        .out1_valid(o1v[2]), .out1_ready(o1r[2]), .out1_data(o1d[2]),
        .outCtrl_valid(cv[2]), .outCtrl_ready(cr[2])
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int i, input int kind, input elem_t d);
        exp_t e;
        e.inst = 2'(i);
        e.kind = 2'(kind);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_stream(input int i, input elem_t start, input elem_t step, input int n);
        elem_t v;
        v = start;
        for (int k = 0; k < n; k++) begin
            push_exp(i, 0, v);
            v = v + step;
        end
        push_exp(i, 1, '0);
        push_exp(i, 2, '0);
    endtask

    task automatic check_xfer(input int i, input int kind, input elem_t d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected inst %0d kind %0d data %h, expected no transfer", i, kind, d);
        end else begin
            e = exp_q.pop_front();
            if (int'(e.inst) != i || int'(e.kind) != kind || e.data !== d) begin
                errors++;
                $display("FAIL xfer got inst %0d kind %0d data %h expected inst %0d kind %0d data %h",
                         i, kind, d, e.inst, e.kind, e.data);
            end
        end
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready driver: all ready, random element/flag backpressure, or completion held off.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            case (rdy_mode)
                1: begin
                    o0r[i] = 1'($urandom_range(0, 1));
                    o1r[i] = 1'($urandom_range(0, 1));
                    cr[i]  = 1'b1;
                end
                2: begin
                    o0r[i] = 1'b1;
                    o1r[i] = 1'b1;
                    cr[i]  = 1'b0;
                end
                default: begin
                    o0r[i] = 1'b1;
                    o1r[i] = 1'b1;
                    cr[i]  = 1'b1;
                end
            endcase
        end
    end

    // Monitor: samples on the falling edge the transfers the next rising edge will make.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) stall0[i] = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (stall0[i]) begin
                    checks++;
                    if (!o0v[i] || o0d[i] !== prev_d[i]) begin
                        errors++;
                        $display("FAIL hold inst %0d got valid %0b data %h expected valid 1 data %h",
                                 i, o0v[i], o0d[i], prev_d[i]);
                    end
                end
                if (o1v[i]) begin
                    checks++;
                    if (o0v[i] && o1d[i]) begin
                        errors++;
                        $display("FAIL elem_vs_eos inst %0d got out0_valid 1 with out1_data 1 expected out0_valid 0", i);
                    end
                end
                if (o0v[i] && o1v[i] && o0r[i] && o1r[i] && !o1d[i]) begin
                    check_xfer(i, 0, o0d[i]);
                    if (i == 0) n_elem++;
                end else if (o1v[i] && o1r[i] && o1d[i]) begin
                    check_xfer(i, 1, '0);
                end
                if (cv[i] && cr[i]) begin
                    check_xfer(i, 2, '0);
                    ctrl_cyc = cyc;
                end
                if (i == 1 && o0v[1]) seen_o0v1 = 1'b1;
                stall0[i] = o0v[i] && !(o0r[i] && o1r[i]);
                prev_d[i] = o0d[i];
            end
        end
    end

    task automatic start_token(input int i);
        bit ok;
        ok = 1'b0;
        in_v[i] = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_r[i]) begin
                accept_cyc = cyc;
                ok = 1'b1;
                @(posedge clk);
                #1;
                in_v[i] = 1'b0;
            end
        end
        if (!ok) begin
            in_v[i] = 1'b0;
            checks++;
            errors++;
            $display("FAIL start_timeout inst %0d got inCtrl_ready 0 expected 1 within 50 cycles", i);
        end
    endtask

    task automatic wait_drain(input int limit, input string name);
        for (int k = 0; k < limit && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got %0d pending transfers expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_v[i] = 1'b0;
            o0r[i]  = 1'b1;
            o1r[i]  = 1'b1;
            cr[i]   = 1'b1;
            stall0[i] = 1'b0;
            prev_d[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_in_ready%0d", i), 64'(in_r[i]), 64'd1);
            check_eq($sformatf("rst_out0_valid%0d", i), 64'(o0v[i]), 64'd0);
            check_eq($sformatf("rst_out1_valid%0d", i), 64'(o1v[i]), 64'd0);
            check_eq($sformatf("rst_ctrl_valid%0d", i), 64'(cv[i]), 64'd0);
            check_eq($sformatf("rst_out0_data%0d", i), o0d[i], 64'd0);
            check_eq($sformatf("rst_out1_data%0d", i), 64'(o1d[i]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default stream, consumers always ready.
        push_stream(0, 64'd0, 64'd1, 10);
        start_token(0);
        wait_drain(100, "basic");
        check_eq("basic_latency", 64'(ctrl_cyc - accept_cyc), 64'd12);

        // Independent random backpressure on out0/out1.
        rdy_mode = 1;
        push_stream(0, 64'd0, 64'd1, 10);
        start_token(0);
        wait_drain(2000, "backpressure");
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Empty stream: EOS only.
        push_exp(1, 1, '0);
        push_exp(1, 2, '0);
        start_token(1);
        wait_drain(100, "count0");
        check_eq("count0_latency", 64'(ctrl_cyc - accept_cyc), 64'd2);

        // Wrapping 64-bit sequence.
        push_exp(2, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        push_exp(2, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp(2, 0, 64'h0000_0000_0000_0000);
        push_exp(2, 0, 64'h0000_0000_0000_0001);
        push_exp(2, 1, '0);
        push_exp(2, 2, '0);
        start_token(2);
        wait_drain(100, "wrap");

        // Reset after three elements abandons the stream; a new start restarts it.
        push_stream(0, 64'd0, 64'd1, 10);
        n_elem = 0;
        start_token(0);
        for (int k = 0; k < 100 && n_elem < 3; k++) begin
            @(posedge clk);
            #2;
        end
        check_eq("midrst_elems", 64'(n_elem), 64'd3);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 64'(in_r[0]), 64'd1);
        check_eq("midrst_out0_valid", 64'(o0v[0]), 64'd0);
        check_eq("midrst_out1_valid", 64'(o1v[0]), 64'd0);
        check_eq("midrst_ctrl_valid", 64'(cv[0]), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_stream(0, 64'd0, 64'd1, 10);
        start_token(0);
        wait_drain(100, "restart");

        // Completion held off while a new start token is offered.
        rdy_mode = 2;
        push_stream(0, 64'd0, 64'd1, 10);
        start_token(0);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 60 && !seen; k++) begin
                @(negedge clk);
                seen = cv[0];
            end
            check_eq("hold_reach_done", 64'(seen), 64'd1);
        end
        in_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("hold_in_ready", 64'(in_r[0]), 64'd0);
            check_eq("hold_ctrl_valid", 64'(cv[0]), 64'd1);
        end
        push_stream(0, 64'd0, 64'd1, 10);
        rdy_mode = 0;
        start_token(0);
        wait_drain(100, "second_stream");

        check_eq("count0_no_out0", 64'(seen_o0v1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
